// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared definitions for the RV32I instruction-fetch stage:
//     XLEN              datapath width (32)
//     NOP_INSTR_WORD    addi x0,x0,0, used as the bubble instruction
//     RESET_PC_DEFAULT  default first fetch address after reset
//     fetch_state_e     fetch control state, encoded as {req_valid, skid_valid}
//     fetch_entry_t     {pc, instr} pair carried through the skid buffer
//     next_seq_pc()     sequential successor of a PC (+4, wraps mod 2^32)
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_WORD   = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // The encoding is deliberately {req_valid, skid_valid} so the bits read
    // directly as "a ROM request is in flight" and "the skid holds an entry".
    // The combination 2'b11 is not a legal state and has no enumerator.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,  // nothing in flight, skid empty
        ST_HELD  = 2'b01,  // stalled, in-flight ROM word parked in the skid
        ST_RUN   = 2'b10   // one ROM request outstanding, data arrives next cycle
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential PC; the adder simply drops the carry so 0xFFFF_FFFC -> 0.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage : if_fetch_stage_pkg

// File: rtl/if_fetch_stage_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry {pc, instr} holding register. The synchronous ROM only presents
//   its data for a single cycle, so when the pipeline stalls with a request in
//   flight the returned word is parked here until the stall releases.
//
// Ports
//   clk    in   1              clock, all updates on posedge
//   rst    in   1              synchronous active-high reset, empties buffer
//   load   in   1              capture din (ignored while already holding)
//   drain  in   1              entry consumed downstream, buffer empties
//   flush  in   1              discard any held entry (highest priority)
//   din    in   fetch_entry_t  entry to capture
//   valid  out  1              buffer holds an entry
//   dout   out  fetch_entry_t  held entry
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import if_fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= 1'b0;
            dout.pc    <= '0;
            dout.instr <= NOP_INSTR_WORD;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load && !valid) begin
            // A held entry is never overwritten: the stalled word must
            // survive however long the stall lasts.
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule : fetch_skid_buf

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the pipelined RV32I core. Owns the architectural
//   PC, issues addresses to a 1-cycle synchronous instruction ROM and presents
//   {pc, pc+4, instr, valid} to the IF/ID boundary. Redirects from EX flush the
//   stage and refetch from the target; stalls from the hazard unit freeze the
//   PC and IF/ID while a skid buffer catches the word already in flight.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   NOP_INSTR   instruction word driven while id_valid_o=0
//
// Ports
//   clk            in   1   single clock, posedge
//   rst            in   1   synchronous reset, active-high
//   stall_i        in   1   hold PC and IF/ID outputs
//   redirect_i     in   1   taken branch / jal / jalr: flush and refetch
//   redirect_pc_i  in   32  redirect target
//   imem_en_o      out  1   ROM read enable (combinational)
//   imem_addr_o    out  32  ROM address, equals the PC register
//   imem_rdata_i   in   32  ROM data, valid the cycle after imem_en_o=1
//   id_pc_o        out  32  PC of the instruction in IF/ID
//   id_npc_o       out  32  id_pc_o + 4
//   id_instr_o     out  32  instruction word
//   id_valid_o     out  1   IF/ID holds a real instruction
//   misalign_o     out  1   sticky: a redirect target with [1:0]!=0 was seen
//
// Timing
//   Reset released at cycle 0 issues RESET_PC; id_valid_o rises at cycle 2.
//   Redirect at cycle N: target issued at N+1, visible in IF/ID at N+3.
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_en_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_npc_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic            id_valid_o,
    output logic            misalign_o
);

    // Handshake with the ROM and IF/ID: an address is requested in a cycle
    // where imem_en_o=1 and its data must be consumed (into IF/ID or the
    // skid) on the very next clock edge; IF/ID only advances when stall_i=0,
    // and a redirect kills everything requested or held before it.

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_e    state_q;      // {req_valid, skid_valid}, visible for debug
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;         // next address to fetch
    logic [XLEN-1:0] req_pc_q;     // address of the outstanding ROM request

    logic            issue;
    logic            skid_load;
    logic            skid_drain;
    logic            skid_flush;
    logic            skid_valid;
    fetch_entry_t    skid_din;
    fetch_entry_t    skid_dout;

    // IF/ID load source selection
    logic            load_valid;
    fetch_entry_t    load_entry;

    // ------------------------------------------------------------------
    // Fetch control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        if (redirect_i) begin
            // Redirect wins over stall: drop the in-flight request and any
            // parked word, and do not fetch in this cycle.
            state_d    = ST_EMPTY;
            skid_flush = 1'b1;
        end else if (stall_i) begin
            // The word for an outstanding request is on the ROM bus only
            // now, so park it. HELD and EMPTY simply persist.
            if (state_q == ST_RUN) begin
                state_d   = ST_HELD;
                skid_load = 1'b1;
            end
        end else begin
            // Unstalled: always fetch pc_q. If a word was parked it drains
            // into IF/ID in the same cycle, so the refetch lines up behind it.
            issue   = 1'b1;
            state_d = ST_RUN;
            if (state_q == ST_HELD) begin
                skid_drain = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // ROM interface
    // ------------------------------------------------------------------
    assign imem_en_o   = issue & ~rst;
    assign imem_addr_o = pc_q;

    // ------------------------------------------------------------------
    // PC and outstanding-request address
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else if (redirect_i) begin
            // Target taken exactly as given, including misaligned low bits.
            pc_q <= redirect_pc_i;
        end else if (issue) begin
            pc_q     <= next_seq_pc(pc_q);
            req_pc_q <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            misalign_o <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    always_comb begin
        skid_din.pc    = req_pc_q;
        skid_din.instr = imem_rdata_i;
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .flush (skid_flush),
        .din   (skid_din),
        .valid (skid_valid),
        .dout  (skid_dout)
    );

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    // A parked word is older than anything on the ROM bus, so it goes first.
    always_comb begin
        load_valid       = 1'b0;
        load_entry.pc    = req_pc_q;
        load_entry.instr = NOP_INSTR;
        if (skid_valid) begin
            load_valid = 1'b1;
            load_entry = skid_dout;
        end else if (state_q == ST_RUN) begin
            load_valid       = 1'b1;
            load_entry.pc    = req_pc_q;
            load_entry.instr = imem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_npc_o   <= '0;
            id_instr_o <= NOP_INSTR;
        end else if (redirect_i) begin
            id_valid_o <= 1'b0;
            id_instr_o <= NOP_INSTR;
        end else if (!stall_i) begin
            id_valid_o <= load_valid;
            id_instr_o <= load_valid ? load_entry.instr : NOP_INSTR;
            // PC fields keep their last value across bubbles.
            if (load_valid) begin
                id_pc_o  <= load_entry.pc;
                id_npc_o <= next_seq_pc(load_entry.pc);
            end
        end
    end

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Two fetch stages (RESET_PC = 0 and RESET_PC = 0xFFFF_FFF8) share the same
//   control stimulus, each with its own synchronous ROM. A reference model per
//   instance tracks the fetch address and a FIFO of addresses that have been
//   requested but not yet delivered to IF/ID; every cycle the outputs are
//   compared against it, plus directed constant checks at key points.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] LO_RST  = 32'h0000_0000;
    localparam logic [31:0] HI_RST  = 32'hFFFF_FFF8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        lo_en,    hi_en;
    logic [31:0] lo_addr,  hi_addr;
    logic [31:0] lo_rdata, hi_rdata;
    logic [31:0] lo_pc,    hi_pc;
    logic [31:0] lo_npc,   hi_npc;
    logic [31:0] lo_instr, hi_instr;
    logic        lo_valid, hi_valid;
    logic        lo_mis,   hi_mis;

    if_fetch_stage #(.RESET_PC(LO_RST), .NOP_INSTR(NOP)) dut_lo (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_en_o(lo_en), .imem_addr_o(lo_addr),
        .imem_rdata_i(lo_rdata), .id_pc_o(lo_pc), .id_npc_o(lo_npc),
        .id_instr_o(lo_instr), .id_valid_o(lo_valid), .misalign_o(lo_mis)
    );

    if_fetch_stage #(.RESET_PC(HI_RST), .NOP_INSTR(NOP)) dut_hi (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_en_o(hi_en), .imem_addr_o(hi_addr),
        .imem_rdata_i(hi_rdata), .id_pc_o(hi_pc), .id_npc_o(hi_npc),
        .id_instr_o(hi_instr), .id_valid_o(hi_valid), .misalign_o(hi_mis)
    );

    // ------------------------------------------------------------------
    // ROM: address-derived words; garbage when not read so stale data shows
    // ------------------------------------------------------------------
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        lo_rdata <= lo_en ? rom_word(lo_addr) : $urandom;
        hi_rdata <= hi_en ? rom_word(hi_addr) : $urandom;
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: fetch address plus FIFO of requested addresses
    // ------------------------------------------------------------------
    logic [31:0] m_pc    [2];
    logic        m_vld   [2];
    logic [31:0] m_id_pc [2];
    logic [31:0] m_npc   [2];
    logic [31:0] m_instr [2];
    logic        m_mis   [2];
    logic [31:0] exp_q_lo[$];
    logic [31:0] exp_q_hi[$];

    task automatic model_step(input int d, input logic r, input logic st,
                              input logic rd, input logic [31:0] rpc);
        logic [31:0] p;
        int          n;
        n = (d == 0) ? exp_q_lo.size() : exp_q_hi.size();
        if (r) begin
            if (d == 0) exp_q_lo.delete(); else exp_q_hi.delete();
            m_pc[d]    = (d == 0) ? LO_RST : HI_RST;
            m_vld[d]   = 1'b0;
            m_id_pc[d] = 32'h0;
            m_npc[d]   = 32'h0;
            m_instr[d] = NOP;
            m_mis[d]   = 1'b0;
        end else if (rd) begin
            if (d == 0) exp_q_lo.delete(); else exp_q_hi.delete();
            m_pc[d]    = rpc;
            m_vld[d]   = 1'b0;
            m_instr[d] = NOP;
            if (rpc[1:0] != 2'b00) m_mis[d] = 1'b1;
        end else if (!st) begin
            // Oldest requested address (if any) reaches IF/ID, then a new
            // fetch joins the back of the line.
            if (n > 0) begin
                p          = (d == 0) ? exp_q_lo.pop_front() : exp_q_hi.pop_front();
                m_vld[d]   = 1'b1;
                m_id_pc[d] = p;
                m_npc[d]   = p + 32'd4;
                m_instr[d] = rom_word(p);
            end else begin
                m_vld[d]   = 1'b0;
                m_instr[d] = NOP;
            end
            if (d == 0) exp_q_lo.push_back(m_pc[d]); else exp_q_hi.push_back(m_pc[d]);
            m_pc[d] = m_pc[d] + 32'd4;
        end
    endtask

    task automatic check_regs(input int d);
        string nm;
        nm = (d == 0) ? "lo" : "hi";
        check({nm, ".valid"}, {31'h0, (d == 0) ? lo_valid : hi_valid}, {31'h0, m_vld[d]});
        check({nm, ".instr"}, (d == 0) ? lo_instr : hi_instr, m_instr[d]);
        check({nm, ".misalign"}, {31'h0, (d == 0) ? lo_mis : hi_mis}, {31'h0, m_mis[d]});
        if (m_vld[d]) begin
            check({nm, ".pc"},  (d == 0) ? lo_pc  : hi_pc,  m_id_pc[d]);
            check({nm, ".npc"}, (d == 0) ? lo_npc : hi_npc, m_npc[d]);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one clock cycle with the given controls
    // ------------------------------------------------------------------
    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        rst         = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        check("lo.imem_en", {31'h0, lo_en}, {31'h0, ~r & ~st & ~rd});
        check("hi.imem_en", {31'h0, hi_en}, {31'h0, ~r & ~st & ~rd});
        if (!r) begin
            check("lo.imem_addr", lo_addr, m_pc[0]);
            check("hi.imem_addr", hi_addr, m_pc[1]);
        end
        @(posedge clk);
        model_step(0, r, st, rd, rpc);
        model_step(1, r, st, rd, rpc);
        @(negedge clk);
        check_regs(0);
        check_regs(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".lo_valid"}, {31'h0, lo_valid}, 32'h0);
        check({tag, ".lo_pc"},    lo_pc,    32'h0);
        check({tag, ".lo_npc"},   lo_npc,   32'h0);
        check({tag, ".lo_instr"}, lo_instr, NOP);
        check({tag, ".lo_mis"},   {31'h0, lo_mis}, 32'h0);
        check({tag, ".hi_valid"}, {31'h0, hi_valid}, 32'h0);
        check({tag, ".hi_instr"}, hi_instr, NOP);
        check({tag, ".hi_addr"},  hi_addr,  HI_RST);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        r_r, r_st, r_rd;
        logic [31:0] r_pc;

        // Reset
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_reset_values("reset");

        // Straight-line fetch; hi instance wraps through 0xFFFF_FFFC -> 0
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq.lo_valid_c1", {31'h0, lo_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq.lo_pc_c2", lo_pc, 32'h0);
        check("wrap.hi_pc_c2", hi_pc, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq.lo_pc_c3", lo_pc, 32'h4);
        check("wrap.hi_pc_c3", hi_pc, 32'hFFFF_FFFC);
        check("wrap.hi_npc_c3", hi_npc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("seq.lo_pc_c4", lo_pc, 32'h8);
        check("wrap.hi_pc_c4", hi_pc, 32'h0);

        // Stall three cycles holding 0x8, then 0xC, 0x10 back-to-back
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check("stall.lo_pc_hold", lo_pc, 32'h8);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("release.lo_pc0", lo_pc, 32'hC);
        check("release.lo_instr0", lo_instr, rom_word(32'hC));
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("release.lo_pc1", lo_pc, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x40
        step(1'b0, 1'b0, 1'b1, 32'h40);
        check("redir.valid_n1", {31'h0, lo_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir.valid_n2", {31'h0, lo_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir.pc_n3", lo_pc, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("redir.pc_n4", lo_pc, 32'h44);

        // Stall with word parked, then redirect+stall: parked word discarded
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h80);
        check("flush.valid_n1", {31'h0, lo_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("flush.valid_n2", {31'h0, lo_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("flush.pc_n3", lo_pc, 32'h80);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("flush.pc_n4", lo_pc, 32'h84);

        // Misaligned redirect target
        step(1'b0, 1'b0, 1'b1, 32'h42);
        check("mis.set", {31'h0, lo_mis}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mis.pc", lo_pc, 32'h42);
        step(1'b0, 1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mis.sticky", {31'h0, lo_mis}, 32'h1);

        // Reset asserted during a stall
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_reset_values("rst_stall");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r_r  = ($urandom_range(0, 99) < 2);
            r_st = ($urandom_range(0, 99) < 30);
            r_rd = ($urandom_range(0, 99) < 10);
            r_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) r_pc[1:0] = 2'($urandom_range(1, 3));
            step(r_r, r_st, r_rd, r_pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_fetch_stage
